// File: rtl/cdc_req_tx.sv
// cdc_req_tx
//   Four-phase request/acknowledge transmitter toward an asynchronous
//   domain. A word offered on tx_valid/tx_data is captured into data_out
//   and announced by raising req_out. The remote acknowledge is brought in
//   through a two-flop synchronizer. When it is seen high, req_out is
//   dropped. The transfer completes once the acknowledge is seen low again.
//   If no acknowledge arrives within TIMEOUT_CYCLES, the request is
//   withdrawn and timeout pulses. The block still waits for the acknowledge
//   to read low before it accepts again, so a late acknowledge cannot
//   complete the next transfer.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   tx_valid   local side offers tx_data
//   tx_data    word to transfer, captured on acceptance
//   tx_ready   high while a word can be accepted (state IDLE)
//   ack_async  acknowledge from remote domain, asynchronous to clk
//   req_out    registered request level to remote domain
//   data_out   registered data bundle to remote domain
//   done       one-cycle pulse on normal handshake completion
//   timeout    one-cycle pulse when a transfer is abandoned
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer in flight, tx_ready high, req_out low
// REQ_HI  | req_out high, waiting for ack_s or the terminal count
// WAIT_LO | req_out low, waiting for ack_s to return low

module cdc_req_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  input  logic                  ack_async,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  timeout
);

  localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_HI  = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t           state;
  logic             ack_meta;
  logic             ack_s;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;

  // The only place ack_async is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ack_async;
      ack_s    <= ack_meta;
    end
  end

  assign tx_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_out   <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            data_out  <= tx_data;
            req_out   <= 1'b1;
            cnt       <= '0;
            timed_out <= 1'b0;
            state     <= REQ_HI;
          end
        end
        REQ_HI: begin
          // ack is checked first so it wins on the terminal-count cycle
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= WAIT_LO;
          end else if (cnt == CNT_TC) begin
            req_out   <= 1'b0;
            timeout   <= 1'b1;
            timed_out <= 1'b1;
            state     <= WAIT_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!ack_s) begin
            done  <= ~timed_out;
            state <= IDLE;
          end
        end
        default: begin
          req_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_tx.sv
`timescale 1ns/1ps
module tb_cdc_req_tx;

  localparam int DW = 8;
  localparam int TO = 8;

  typedef struct {
    bit            is_to;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          ack_async;
  logic          ack_drv;
  logic          ack_follow;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          done;
  logic          timeout;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   to_cnt = 0;
  int   last_done_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ack_follow models a remote side that acknowledges immediately
  assign ack_async = ack_follow ? req_out : ack_drv;

  cdc_req_tx #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .ack_async (ack_async),
    .req_out   (req_out),
    .data_out  (data_out),
    .done      (done),
    .timeout   (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && (done || timeout)) begin
        check_eq("pulse_excl", {31'd0, done & timeout}, 0);
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (timeout) to_cnt++;
        check_eq("sb_pending", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("sb_kind", {31'd0, timeout}, {31'd0, mon_e.is_to});
          check_eq("sb_data", {24'd0, data_out}, {24'd0, mon_e.data});
        end
      end
    end
  endtask

  // kind: 0 expect done, 1 expect timeout, 2 expect nothing
  task automatic accept(input logic [DW-1:0] d, input int kind);
    exp_t e;
    tx_data  = d;
    tx_valid = 1'b1;
    if (kind != 2) begin
      e.is_to = (kind == 1);
      e.data  = d;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_eq("acc_req", {31'd0, req_out}, 1);
    check_eq("acc_data", {24'd0, data_out}, {24'd0, d});
    check_eq("acc_busy", {31'd0, tx_ready}, 0);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!tx_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, tx_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int d0;
    int t0;
    int acc_cyc;
    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    ack_drv    = 1'b0;
    ack_follow = 1'b0;
    fork
      monitor();
    join_none

    // reset values, with stimulus that must be ignored
    repeat (2) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    ack_drv  = 1'b1;
    @(negedge clk);
    check_eq("rst_req", {31'd0, req_out}, 0);
    check_eq("rst_data", {24'd0, data_out}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_to", {31'd0, timeout}, 0);
    check_eq("rst_ready", {31'd0, tx_ready}, 1);
    tx_valid = 1'b0;
    ack_drv  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_data = 8'h33;
    @(negedge clk);
    check_eq("idle_data_hold", {24'd0, data_out}, 0);
    check_eq("idle_req_low", {31'd0, req_out}, 0);

    // normal transfer, ack 2 cycles after req rise, release 2 after fall
    d0 = done_cnt;
    wait_ready("n_ready0", 5);
    accept(8'hA5, 0);
    repeat (2) @(posedge clk);
    #1 ack_drv = 1'b1;
    n = 0;
    while (req_out && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("n_req_fall", {31'd0, req_out}, 0);
    repeat (2) @(posedge clk);
    #1 ack_drv = 1'b0;
    @(negedge clk);
    wait_ready("n_ready1", 20);
    @(negedge clk);
    check_eq("n_done_cnt", done_cnt - d0, 1);
    check_eq("n_data_hold", {24'd0, data_out}, 8'hA5);

    // minimum latency with an immediately following ack
    ack_follow = 1'b1;
    d0 = done_cnt;
    accept(8'hC3, 0);
    n = 0;
    while (req_out && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("lat_req_fall", n, 3);
    m = 0;
    while (!done && m < 10) begin
      @(posedge clk);
      #1;
      m++;
    end
    check_eq("lat_done", n + m, 6);
    ack_follow = 1'b0;
    @(negedge clk);
    check_eq("lat_done_cnt", done_cnt - d0, 1);

    // timeout with no ack, then a late ack that rises after the pulse
    d0 = done_cnt;
    t0 = to_cnt;
    wait_ready("to_ready0", 5);
    accept(8'h3C, 1);
    n = 0;
    while (req_out && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("to_req_hi_cycles", n, TO);
    check_eq("to_pulse", {31'd0, timeout}, 1);
    check_eq("to_wait_lo", {31'd0, tx_ready}, 0);
    ack_drv = 1'b1;
    @(posedge clk);
    #1;
    check_eq("to_idle", {31'd0, tx_ready}, 1);
    check_eq("to_pulse_end", {31'd0, timeout}, 0);
    repeat (4) @(posedge clk);
    #1 ack_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("to_no_done", done_cnt - d0, 0);
    check_eq("to_cnt", to_cnt - t0, 1);

    // stale ack: synchronized high right after the timeout, held 5 cycles
    d0 = done_cnt;
    t0 = to_cnt;
    @(negedge clk);
    accept(8'h4B, 1);
    repeat (6) @(posedge clk);
    #1 ack_drv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("stale_to", {31'd0, timeout}, 1);
    repeat (3) @(posedge clk);
    #1 ack_drv = 1'b0;
    check_eq("stale_hold", {31'd0, tx_ready}, 0);
    n = 0;
    while (!tx_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("stale_release", n, 3);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stale_no_done", done_cnt - d0, 0);
    check_eq("stale_to_cnt", to_cnt - t0, 1);

    // ack synchronized on the terminal-count cycle wins over timeout
    d0 = done_cnt;
    t0 = to_cnt;
    @(negedge clk);
    accept(8'h96, 0);
    repeat (5) @(posedge clk);
    #1 ack_drv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("tc_req_hi", {31'd0, req_out}, 1);
    @(posedge clk);
    #1;
    check_eq("tc_req_low", {31'd0, req_out}, 0);
    check_eq("tc_no_to", {31'd0, timeout}, 0);
    ack_drv = 1'b0;
    @(negedge clk);
    wait_ready("tc_ready", 20);
    @(negedge clk);
    check_eq("tc_done_cnt", done_cnt - d0, 1);
    check_eq("tc_to_cnt", to_cnt - t0, 0);

    // back-to-back with tx_valid held high
    ack_follow = 1'b1;
    begin
      exp_t e;
      e.is_to = 1'b0;
      e.data  = 8'h01;
      exp_q.push_back(e);
      tx_data  = 8'h01;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      check_eq("b2b_acc1", {24'd0, data_out}, 8'h01);
      e.data  = 8'h02;
      exp_q.push_back(e);
      tx_data = 8'h02;
    end
    n = 0;
    while (data_out !== 8'h02 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    tx_valid = 1'b0;
    check_eq("b2b_acc2", {24'd0, data_out}, 8'h02);
    check_eq("b2b_gap", acc_cyc - last_done_cyc, 1);
    @(negedge clk);
    wait_ready("b2b_ready", 20);
    @(negedge clk);
    ack_follow = 1'b0;

    // reset asserted while in REQ_HI, then a normal transfer
    @(negedge clk);
    accept(8'h5A, 2);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_req", {31'd0, req_out}, 0);
    check_eq("mid_rst_data", {24'd0, data_out}, 0);
    check_eq("mid_rst_ready", {31'd0, tx_ready}, 1);
    check_eq("mid_rst_pulses", {30'd0, done, timeout}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    t0 = to_cnt;
    ack_follow = 1'b1;
    @(negedge clk);
    accept(8'h77, 0);
    @(negedge clk);
    wait_ready("post_rst_ready", 30);
    @(negedge clk);
    ack_follow = 1'b0;
    check_eq("post_rst_done", done_cnt - d0, 1);
    check_eq("post_rst_to", to_cnt - t0, 0);
    check_eq("post_rst_data", {24'd0, data_out}, 8'h77);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
